// File: rtl/booth_product_bcd.sv
// Signed product to sign + BCD converter using sequential double-dabble, one shift per clock.
// Optional BCD_BLANK_LEADING_EN: leading zero digits are presented as 4'hF (LSD never blanked).
module booth_product_bcd #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // once valid is raised, the payload stays stable until that transfer edge.

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [IN_W-1:0]  mag;
    logic [IN_W-1:0]  mag_in;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_final;
    logic [CNT_W-1:0] count;
    logic             sign_r;

    // The most negative input wraps to itself, which read unsigned is the correct magnitude.
    assign mag_in = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

`ifdef BCD_BLANK_LEADING_EN
    always_comb begin
        logic leading;
        leading   = 1'b1;
        bcd_final = bcd;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && (bcd[4*d +: 4] == 4'd0)) begin
                bcd_final[4*d +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign bcd_final = bcd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            bcd      <= '0;
            count    <= '0;
            sign_r   <= 1'b0;
            out_sign <= 1'b0;
            out_bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_data[IN_W-1] && (mag_in != '0);
                        mag    <= mag_in;
                        bcd    <= '0;
                        count  <= CNT_W'(IN_W);
                        state  <= CONV;
                    end
                end
                CONV: begin
                    // One extra cycle after the last shift registers the result.
                    if (count != '0) begin
                        bcd   <= {bcd_adj[BW-2:0], mag[IN_W-1]};
                        mag   <= {mag[IN_W-2:0], 1'b0};
                        count <= count - CNT_W'(1);
                    end else begin
                        out_bcd  <= bcd_final;
                        out_sign <= sign_r;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CONV);
    assign out_valid = (state == HOLD);
    assign dbg_state = state;

endmodule

// File: tb/tb_booth_product_bcd.sv
// Self-checking bench for booth_product_bcd: directed cases plus random products
// compared against a divide-and-modulo decimal reference.
module tb_booth_product_bcd;

    localparam int IN_W   = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;
    localparam int RW     = BW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sign;
    logic [BW-1:0]   out_bcd;
    logic            busy;
    logic [1:0]      dbg_state;

    logic [RW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_pass   = 0;

    booth_product_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_bcd   (out_bcd),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: decimal digits of |value| via division, optional leading blanking.
    function automatic logic [RW-1:0] model(input logic [IN_W-1:0] d);
        int v;
        int m;
        logic [BW-1:0] b;
`ifdef BCD_BLANK_LEADING_EN
        logic lead;
`endif
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BCD_BLANK_LEADING_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && b[4*i +: 4] == 4'd0) b[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {(v < 0), b};
    endfunction

    // Driver: one full transaction, called and returning on a falling edge.
    task automatic convert(input logic [IN_W-1:0] d, input int stall, input bit poke);
        int lat;
        logic [RW-1:0] exp;
        exp_q.push_back(model(d));
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = IN_W'($urandom_range(0, 255));
        check("busy_conv", 32'(busy), 32'd1);
        check("in_ready_conv", 32'(in_ready), 32'd0);
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 8'h07;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(lat), 32'(IN_W + 1));
        exp = exp_q.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_sign", 32'(out_sign), 32'(exp[RW-1]));
        check("out_bcd", 32'(out_bcd), 32'(exp[BW-1:0]));
        check("in_ready_hold", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sign", 32'(out_sign), 32'(exp[RW-1]));
            check("stall_bcd", 32'(out_bcd), 32'(exp[BW-1:0]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_xfer_valid", 32'(out_valid), 32'd0);
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        convert(8'hC8, 0, 1'b0);
        convert(8'h40, 0, 1'b0);
        convert(8'h80, 0, 1'b0);
        convert(8'h00, 0, 1'b0);
        convert(8'h7F, 5, 1'b0);
        convert(8'h99, 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_ghost_conv", 32'(busy), 32'd0);
            check("no_ghost_valid", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset during a conversion of -1
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_sign", 32'(out_sign), 32'd0);
        check("arst_out_bcd", 32'(out_bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        convert(8'hFF, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            convert(IN_W'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
